// File: rtl/worley_pkg.sv
// Shared types, widths and reset table for the Worley feature-point scheduler.
package worley_pkg;

  localparam int unsigned COORD_W    = 10;
  localparam int unsigned VEL_W      = 4;
  localparam int unsigned CFG_IDX_W  = 2;
  localparam int unsigned MAX_POINTS = 4;
  localparam int unsigned X_MAX_DEF  = 639;
  localparam int unsigned Y_MAX_DEF  = 479;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Velocities are stored as raw two's-complement bit patterns.
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [VEL_W-1:0]   vx;
    logic [VEL_W-1:0]   vy;
  } point_t;

  localparam point_t RESET_TABLE [MAX_POINTS] = '{
    '{x: 10'd100, y: 10'd100, vx: 4'h1, vy: 4'hF},
    '{x: 10'd300, y: 10'd200, vx: 4'hF, vy: 4'h1},
    '{x: 10'd500, y: 10'd400, vx: 4'h2, vy: 4'hF},
    '{x: 10'd100, y: 10'd450, vx: 4'hF, vy: 4'hE}
  };

  function automatic logic [COORD_W-1:0] sat_pos(input logic [COORD_W-1:0] p,
                                                 input logic [COORD_W-1:0] lim);
    return (p > lim) ? lim : p;
  endfunction

  // The most negative velocity has no negation, so it is pulled in by one.
  function automatic logic signed [VEL_W-1:0] sat_vel(input logic [VEL_W-1:0] v);
    logic [VEL_W-1:0] most_neg;
    most_neg = {1'b1, {(VEL_W-1){1'b0}}};
    if (v == most_neg) return $signed(most_neg + 1'b1);
    return $signed(v);
  endfunction

endpackage

// File: rtl/worley_point_scheduler_if.sv
// Point reconfiguration port: valid/ready handshake carrying one point record.
interface worley_point_scheduler_if;
  import worley_pkg::*;

  logic                 valid;
  logic                 ready;
  logic [CFG_IDX_W-1:0] idx;
  logic [COORD_W-1:0]   x;
  logic [COORD_W-1:0]   y;
  logic [VEL_W-1:0]     vx;
  logic [VEL_W-1:0]     vy;

  modport master (output valid, idx, x, y, vx, vy, input ready);
  modport slave  (input valid, idx, x, y, vx, vy, output ready);
endinterface

// File: rtl/worley_axis_step.sv
// One-axis position step with reflection at 0 and at the axis maximum.
module worley_axis_step
  import worley_pkg::*;
(
  input  logic [COORD_W-1:0]      p,
  input  logic signed [VEL_W-1:0] v,
  input  logic [COORD_W-1:0]      max,
  output logic [COORD_W-1:0]      p_next,
  output logic signed [VEL_W-1:0] v_next
);

  logic signed [COORD_W+1:0] n;
  logic signed [COORD_W+1:0] lim;

  // Advance, then mirror about whichever edge was crossed and flip direction.
  always_comb begin
    n      = $signed({2'b00, p}) + $signed({{(COORD_W+2-VEL_W){v[VEL_W-1]}}, v});
    lim    = $signed({2'b00, max});
    p_next = COORD_W'(n);
    v_next = v;
    if (n < 0) begin
      p_next = COORD_W'(-n);
      v_next = -v;
    end else if (n > lim) begin
      p_next = COORD_W'((lim <<< 1) - n);
      v_next = -v;
    end
  end

endmodule

// File: rtl/worley_point_scheduler.sv
// Frame-synchronous owner of the Worley feature points: moves them once per
// qualifying frame and publishes shadowed coordinates at a single commit edge.
module worley_point_scheduler
  import worley_pkg::*;
#(
  parameter int unsigned NUM_POINTS = 4,
  parameter int unsigned X_MAX      = X_MAX_DEF,
  parameter int unsigned Y_MAX      = Y_MAX_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_start,
  input  logic                          enable,
  input  logic [3:0]                    step_div,
  worley_point_scheduler_if.slave       cfg,
  output logic [NUM_POINTS*COORD_W-1:0] pts_x,
  output logic [NUM_POINTS*COORD_W-1:0] pts_y,
  output logic                          update_done,
  output logic                          busy,
  output logic                          overrun,
  output logic [15:0]                   frame_cnt
);

  localparam int unsigned        IDX_W    = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_POINTS - 1);
  localparam logic [COORD_W-1:0] XM       = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] YM       = COORD_W'(Y_MAX);

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [3:0]              div;

  logic [COORD_W-1:0]      wx  [NUM_POINTS];
  logic [COORD_W-1:0]      wy  [NUM_POINTS];
  logic signed [VEL_W-1:0] wvx [NUM_POINTS];
  logic signed [VEL_W-1:0] wvy [NUM_POINTS];

  logic [COORD_W-1:0]      px_next, py_next;
  logic signed [VEL_W-1:0] vx_next, vy_next;

  logic                    cfg_hit;
  logic [IDX_W-1:0]        cfg_slot;
  logic [COORD_W-1:0]      cfg_x_sat, cfg_y_sat;
  logic signed [VEL_W-1:0] cfg_vx_sat, cfg_vy_sat;

  assign cfg.ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Saturate incoming config; out-of-range indices are accepted but dropped.
  always_comb begin
    cfg_hit    = cfg.valid && (state == IDLE) && (32'(cfg.idx) < NUM_POINTS);
    cfg_slot   = cfg.idx[IDX_W-1:0];
    cfg_x_sat  = sat_pos(cfg.x, XM);
    cfg_y_sat  = sat_pos(cfg.y, YM);
    cfg_vx_sat = sat_vel(cfg.vx);
    cfg_vy_sat = sat_vel(cfg.vy);
  end

  worley_axis_step u_step_x (
    .p      (wx[idx]),
    .v      (wvx[idx]),
    .max    (XM),
    .p_next (px_next),
    .v_next (vx_next)
  );

  worley_axis_step u_step_y (
    .p      (wy[idx]),
    .v      (wvy[idx]),
    .max    (YM),
    .p_next (py_next),
    .v_next (vy_next)
  );

  // Control FSM plus working/shadow point registers.
  // A config write lands in IDLE on the same edge that may start UPDATE, so
  // the update that follows naturally sees the new values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      div         <= '0;
      frame_cnt   <= '0;
      update_done <= 1'b0;
      overrun     <= 1'b0;
      for (int unsigned i = 0; i < NUM_POINTS; i++) begin
        wx[i]                          <= RESET_TABLE[i].x;
        wy[i]                          <= RESET_TABLE[i].y;
        wvx[i]                         <= $signed(RESET_TABLE[i].vx);
        wvy[i]                         <= $signed(RESET_TABLE[i].vy);
        pts_x[i*COORD_W +: COORD_W]    <= RESET_TABLE[i].x;
        pts_y[i*COORD_W +: COORD_W]    <= RESET_TABLE[i].y;
      end
    end else begin
      update_done <= 1'b0;
      if (frame_start && (state != IDLE)) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (cfg_hit) begin
            wx[cfg_slot]  <= cfg_x_sat;
            wy[cfg_slot]  <= cfg_y_sat;
            wvx[cfg_slot] <= cfg_vx_sat;
            wvy[cfg_slot] <= cfg_vy_sat;
          end
          if (frame_start) begin
            if (div == step_div) begin
              div <= '0;
              if (enable) begin
                state <= UPDATE;
                idx   <= '0;
              end
            end else begin
              div <= div + 4'd1;
            end
          end
        end
        UPDATE: begin
          wx[idx]  <= px_next;
          wy[idx]  <= py_next;
          wvx[idx] <= vx_next;
          wvy[idx] <= vy_next;
          if (idx == LAST_IDX) state <= COMMIT;
          else                 idx   <= idx + 1'b1;
        end
        COMMIT: begin
          for (int unsigned i = 0; i < NUM_POINTS; i++) begin
            pts_x[i*COORD_W +: COORD_W] <= wx[i];
            pts_y[i*COORD_W +: COORD_W] <= wy[i];
          end
          frame_cnt   <= frame_cnt + 16'd1;
          update_done <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_worley_point_scheduler.sv
// Directed bench for worley_point_scheduler: table of frame/config vectors
// followed by hand sequences for divider, handshake, overrun and reset.
module tb_worley_point_scheduler;

  logic        clk;
  logic        rst_n;
  logic        frame_start;
  logic        enable;
  logic [3:0]  step_div;
  logic [39:0] pts_x;
  logic [39:0] pts_y;
  logic        update_done;
  logic        busy;
  logic        overrun;
  logic [15:0] frame_cnt;

  int n_tests;
  int n_fail;

  worley_point_scheduler_if cfg_if ();

  worley_point_scheduler #(
    .NUM_POINTS (4),
    .X_MAX      (639),
    .Y_MAX      (479)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .enable      (enable),
    .step_div    (step_div),
    .cfg         (cfg_if),
    .pts_x       (pts_x),
    .pts_y       (pts_y),
    .update_done (update_done),
    .busy        (busy),
    .overrun     (overrun),
    .frame_cnt   (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        do_cfg;
    logic [1:0]  idx;
    logic [9:0]  cx;
    logic [9:0]  cy;
    logic [3:0]  cvx;
    logic [3:0]  cvy;
    logic [39:0] ex;
    logic [39:0] ey;
    logic [15:0] ecnt;
  } vec_t;

  vec_t vecs [8];

  function automatic vec_t mk(input logic dc, input logic [1:0] i,
                              input logic [9:0] x, input logic [9:0] y,
                              input logic [3:0] vx, input logic [3:0] vy,
                              input logic [39:0] ex, input logic [39:0] ey,
                              input logic [15:0] ecnt);
    vec_t r;
    r.do_cfg = dc; r.idx = i; r.cx = x; r.cy = y; r.cvx = vx; r.cvy = vy;
    r.ex = ex; r.ey = ey; r.ecnt = ecnt;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One frame_start pulse; watches 9 cycles after the sampling edge.
  task automatic pulse_frame(output int first_done, output int n_done);
    first_done = -1;
    n_done     = 0;
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      if (update_done) begin
        n_done++;
        if (first_done < 0) first_done = j;
      end
    end
  endtask

  task automatic send_cfg(input logic [1:0] i, input logic [9:0] x, input logic [9:0] y,
                          input logic [3:0] vx, input logic [3:0] vy);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    cfg_if.valid = 1'b1; cfg_if.idx = i; cfg_if.x = x; cfg_if.y = y;
    cfg_if.vx = vx; cfg_if.vy = vy;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (cfg_if.ready) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk); #1 cfg_if.valid = 1'b0;
    check("cfg_accept", 64'(got), 64'd1);
  endtask

  initial begin
    int         fd;
    int         nd;
    int         total;
    int         rdy_at;
    logic [39:0] prev_x;
    logic [39:0] prev_y;

    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0; frame_start = 1'b0; enable = 1'b1; step_div = 4'd0;
    cfg_if.valid = 1'b0; cfg_if.idx = '0; cfg_if.x = '0; cfg_if.y = '0;
    cfg_if.vx = '0; cfg_if.vy = '0;

    vecs[0] = mk(1'b0, 2'd0, 10'd0,    10'd0,    4'h0, 4'h0,
                 {10'd99, 10'd502, 10'd299, 10'd101}, {10'd448, 10'd399, 10'd201, 10'd99}, 16'd1);
    vecs[1] = mk(1'b1, 2'd0, 10'd638,  10'd99,   4'h3, 4'hF,
                 {10'd98, 10'd504, 10'd298, 10'd637}, {10'd446, 10'd398, 10'd202, 10'd98}, 16'd2);
    vecs[2] = mk(1'b0, 2'd0, 10'd0,    10'd0,    4'h0, 4'h0,
                 {10'd97, 10'd506, 10'd297, 10'd634}, {10'd444, 10'd397, 10'd203, 10'd97}, 16'd3);
    vecs[3] = mk(1'b1, 2'd1, 10'd297,  10'd0,    4'hF, 4'hE,
                 {10'd96, 10'd508, 10'd296, 10'd631}, {10'd442, 10'd396, 10'd2,   10'd96}, 16'd4);
    vecs[4] = mk(1'b0, 2'd0, 10'd0,    10'd0,    4'h0, 4'h0,
                 {10'd95, 10'd510, 10'd295, 10'd628}, {10'd440, 10'd395, 10'd4,   10'd95}, 16'd5);
    vecs[5] = mk(1'b1, 2'd2, 10'd1000, 10'd1023, 4'h8, 4'h0,
                 {10'd94, 10'd632, 10'd294, 10'd625}, {10'd438, 10'd479, 10'd6,   10'd94}, 16'd6);
    vecs[6] = mk(1'b1, 2'd3, 10'd3,    10'd478,  4'h9, 4'h5,
                 {10'd4,  10'd625, 10'd293, 10'd622}, {10'd475, 10'd479, 10'd8,   10'd93}, 16'd7);
    vecs[7] = mk(1'b0, 2'd0, 10'd0,    10'd0,    4'h0, 4'h0,
                 {10'd11, 10'd618, 10'd292, 10'd619}, {10'd470, 10'd479, 10'd10,  10'd92}, 16'd8);

    // Reset state
    #20;
    check("rst_pts_x", 64'(pts_x), 64'({10'd100, 10'd500, 10'd300, 10'd100}));
    check("rst_pts_y", 64'(pts_y), 64'({10'd450, 10'd400, 10'd200, 10'd100}));
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(cfg_if.ready), 64'd1);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_update_done", 64'(update_done), 64'd0);
    #2 rst_n = 1'b1;

    // Table: optional config, then one qualifying frame
    for (int v = 0; v < 8; v++) begin
      prev_x = pts_x;
      prev_y = pts_y;
      if (vecs[v].do_cfg) begin
        send_cfg(vecs[v].idx, vecs[v].cx, vecs[v].cy, vecs[v].cvx, vecs[v].cvy);
        check("cfg_no_early_x", 64'(pts_x), 64'(prev_x));
        check("cfg_no_early_y", 64'(pts_y), 64'(prev_y));
      end
      pulse_frame(fd, nd);
      check("done_latency", 64'(fd), 64'd5);
      check("done_count", 64'(nd), 64'd1);
      check("vec_pts_x", 64'(pts_x), 64'(vecs[v].ex));
      check("vec_pts_y", 64'(pts_y), 64'(vecs[v].ey));
      check("vec_frame_cnt", 64'(frame_cnt), 64'(vecs[v].ecnt));
    end

    // Divider: step_div=2, six pulses -> two commits
    step_div = 4'd2;
    total = 0;
    for (int p = 0; p < 6; p++) begin
      pulse_frame(fd, nd);
      total += nd;
    end
    check("div_commits", 64'(total), 64'd2);
    check("div_frame_cnt", 64'(frame_cnt), 64'd10);
    check("div_pts_x", 64'(pts_x), 64'({10'd25, 10'd604, 10'd290, 10'd613}));
    check("div_pts_y", 64'(pts_y), 64'({10'd460, 10'd479, 10'd14, 10'd90}));

    // Same pulses with motion frozen
    enable = 1'b0;
    total = 0;
    for (int p = 0; p < 6; p++) begin
      pulse_frame(fd, nd);
      total += nd;
    end
    check("frozen_commits", 64'(total), 64'd0);
    check("frozen_frame_cnt", 64'(frame_cnt), 64'd10);
    check("frozen_pts_x", 64'(pts_x), 64'({10'd25, 10'd604, 10'd290, 10'd613}));
    enable = 1'b1;
    step_div = 4'd0;

    // Config and frame_start on the same edge: update uses the new P0
    @(posedge clk); #1;
    frame_start = 1'b1;
    cfg_if.valid = 1'b1; cfg_if.idx = 2'd0; cfg_if.x = 10'd10; cfg_if.y = 10'd20;
    cfg_if.vx = 4'h1; cfg_if.vy = 4'h1;
    @(negedge clk);
    check("simul_ready", 64'(cfg_if.ready), 64'd1);
    @(posedge clk); #1;
    frame_start = 1'b0;
    cfg_if.valid = 1'b0;
    fd = -1;
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      if (update_done && fd < 0) fd = j;
    end
    check("simul_latency", 64'(fd), 64'd5);
    check("simul_pts_x", 64'(pts_x), 64'({10'd32, 10'd597, 10'd289, 10'd11}));
    check("simul_pts_y", 64'(pts_y), 64'({10'd455, 10'd479, 10'd16, 10'd21}));

    // Config held during UPDATE: refused until the FSM is back in IDLE
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    cfg_if.valid = 1'b1; cfg_if.idx = 2'd1; cfg_if.x = 10'd100; cfg_if.y = 10'd100;
    cfg_if.vx = 4'h0; cfg_if.vy = 4'h0;
    rdy_at = -1;
    fd = -1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (j == 0) begin
        check("upd_ready_low", 64'(cfg_if.ready), 64'd0);
        check("upd_busy", 64'(busy), 64'd1);
      end
      if (update_done && fd < 0) fd = j;
      if (cfg_if.valid && cfg_if.ready && rdy_at < 0) begin
        rdy_at = j;
        @(posedge clk); #1 cfg_if.valid = 1'b0;
      end
    end
    if (cfg_if.valid) cfg_if.valid = 1'b0;
    check("upd_accept_at", 64'(rdy_at), 64'd5);
    check("upd_done_at", 64'(fd), 64'd5);
    check("upd_pts_x", 64'(pts_x), 64'({10'd39, 10'd590, 10'd288, 10'd12}));
    check("upd_pts_y", 64'(pts_y), 64'({10'd450, 10'd479, 10'd18, 10'd22}));
    pulse_frame(fd, nd);
    check("late_cfg_pts_x", 64'(pts_x), 64'({10'd46, 10'd583, 10'd100, 10'd13}));
    check("late_cfg_pts_y", 64'(pts_y), 64'({10'd445, 10'd479, 10'd100, 10'd23}));
    check("late_cfg_cnt", 64'(frame_cnt), 64'd13);

    // Overrun: second pulse two cycles after the first
    check("pre_overrun", 64'(overrun), 64'd0);
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    total = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (update_done) total++;
    end
    check("ovr_commits", 64'(total), 64'd1);
    check("ovr_flag", 64'(overrun), 64'd1);
    check("ovr_cnt", 64'(frame_cnt), 64'd14);
    check("ovr_pts_x", 64'(pts_x), 64'({10'd53, 10'd576, 10'd100, 10'd14}));
    pulse_frame(fd, nd);
    check("ovr_sticky", 64'(overrun), 64'd1);

    // Asynchronous reset in the middle of UPDATE
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_pts_x", 64'(pts_x), 64'({10'd100, 10'd500, 10'd300, 10'd100}));
    check("mid_rst_pts_y", 64'(pts_y), 64'({10'd450, 10'd400, 10'd200, 10'd100}));
    check("mid_rst_cnt", 64'(frame_cnt), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_overrun", 64'(overrun), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    pulse_frame(fd, nd);
    check("post_rst_latency", 64'(fd), 64'd5);
    check("post_rst_pts_x", 64'(pts_x), 64'({10'd99, 10'd502, 10'd299, 10'd101}));
    check("post_rst_pts_y", 64'(pts_y), 64'({10'd448, 10'd399, 10'd201, 10'd99}));
    check("post_rst_cnt", 64'(frame_cnt), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
